// File: rtl/lsm_sequencer.sv
// Register-list sequencer for ARM LDM/STM: walks the IR register list lowest-first,
// reports the current register, transfer index and count, and supplies start/writeback offsets.
module lsm_sequencer #(
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       IR,
    input  logic              LSM_EN,
    input  logic              LSM_STEP,
    output logic              LSM_DETECT,
    output logic              LSM_BUSY,
    output logic [3:0]        LSM_REG,
    output logic [4:0]        LSM_INDEX,
    output logic [4:0]        LSM_COUNT,
    output logic              LSM_END,
    output logic [ADDR_W-1:0] LSM_START_OFS,
    output logic [ADDR_W-1:0] LSM_WB_OFS
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_EMPTY  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_list;
    logic [4:0]         r_count;
    logic [4:0]         r_index;
    logic [ADDR_W-1:0]  r_start_ofs;
    logic [ADDR_W-1:0]  r_wb_ofs;

    logic [4:0]         w_pop;
    logic [ADDR_W-1:0]  w_stride;
    logic [ADDR_W-1:0]  w_start;
    logic [ADDR_W-1:0]  w_wb;
    logic               w_launch;
    logic               w_one_left;
    logic [3:0]         w_lowest;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    assign LSM_DETECT = (IR[27:25] == 3'b100);
    assign w_launch   = LSM_EN & LSM_DETECT;
    assign w_pop      = popcount16(IR[15:0]);
    assign w_stride   = ADDR_W'(w_pop) * ADDR_W'(WORD_BYTES);
    assign w_wb       = IR[23] ? w_stride : (-w_stride);

    // P = IR[24], U = IR[23]; DA start works out to (-n*stride + stride).
    always_comb begin
        w_start = '0;
        case ({IR[24], IR[23]})
            2'b01:   w_start = '0;
            2'b11:   w_start = ADDR_W'(WORD_BYTES);
            2'b00:   w_start = (-w_stride) + ADDR_W'(WORD_BYTES);
            default: w_start = -w_stride;
        endcase
    end

    assign w_one_left = (r_list != 16'd0) && ((r_list & (r_list - 16'd1)) == 16'd0);
    assign w_lowest   = lowest_set(r_list);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        LSM_BUSY = 1'b0;
        LSM_REG  = 4'd0;
        LSM_END  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_next = (w_pop != 5'd0) ? S_ACTIVE : S_EMPTY;
                end
            end
            S_ACTIVE: begin
                LSM_BUSY = 1'b1;
                LSM_REG  = w_lowest;
                LSM_END  = w_one_left;
                if (LSM_STEP && w_one_left) begin
                    w_next = S_IDLE;
                end
            end
            S_EMPTY: begin
                LSM_BUSY = 1'b1;
                LSM_END  = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Count and offsets only change on a launch, so they stay valid after the sequence ends.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_list      <= '0;
            r_count     <= '0;
            r_index     <= '0;
            r_start_ofs <= '0;
            r_wb_ofs    <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_launch) begin
                r_list      <= IR[15:0];
                r_count     <= w_pop;
                r_index     <= '0;
                r_start_ofs <= w_start;
                r_wb_ofs    <= w_wb;
            end
        end else if (r_state == S_ACTIVE && LSM_STEP) begin
            r_list  <= r_list & (r_list - 16'd1);
            r_index <= r_index + 5'd1;
        end
    end

    assign LSM_INDEX     = r_index;
    assign LSM_COUNT     = r_count;
    assign LSM_START_OFS = r_start_ofs;
    assign LSM_WB_OFS    = r_wb_ofs;

endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
- Register-list sequencer for ARM load/store-multiple (LDM/STM) instructions.
- Sits beside datapath_pepo and directly upstream of cu_pepo; produces LSM_DETECT and LSM_END for the control unit.
- Walks the IR register list lowest-to-highest and supplies the current register number to the register-file port muxes.
- Supplies start-address and writeback offsets for the MAR/base-update path.

Parameters:
- WORD_BYTES, 4, byte stride between consecutive transfers.
- ADDR_W, 32, width of the offset outputs.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IR  input  32  instruction register contents.
- LSM_EN  input  1  CU strobe: latch the list from IR and start a sequence.
- LSM_STEP  input  1  CU strobe: current transfer complete (issued after MOC); advance to the next register.
- LSM_DETECT  output  1  combinational, IR[27:25]==3'b100.
- LSM_BUSY  output  1  sequence in progress.
- LSM_REG  output  4  register number for the current transfer.
- LSM_INDEX  output  5  transfer index, 0..n-1.
- LSM_COUNT  output  5  popcount of the latched list, 0..16.
- LSM_END  output  1  current transfer is the last one.
- LSM_START_OFS  output  ADDR_W  offset added to the base to form the first address.
- LSM_WB_OFS  output  ADDR_W  offset added to the base for writeback.

Behaviour:
- Reset (asynchronous) clears everything and forces IDLE:
  - list = 0, LSM_BUSY = 0, LSM_REG = 0, LSM_INDEX = 0, LSM_COUNT = 0, LSM_END = 0, both offsets = 0.
  - LSM_DETECT still follows IR, since it is combinational.
- States: IDLE, ACTIVE, EMPTY.
- IDLE:
  - LSM_EN & LSM_DETECT at an edge: latch list = IR[15:0], P = IR[24], U = IR[23].
  - Register n = popcount(list) into LSM_COUNT and clear LSM_INDEX.
  - Register offsets from n, all two's complement modulo 2^ADDR_W:
    - IA (P=0, U=1): start = 0, wb = +4n
    - IB (P=1, U=1): start = +4, wb = +4n
    - DA (P=0, U=0): start = -4(n-1), wb = -4n
    - DB (P=1, U=0): start = -4n, wb = -4n
  - Next state: ACTIVE if n > 0, otherwise EMPTY.
  - LSM_EN while LSM_DETECT = 0 is ignored; the block stays in IDLE.
- ACTIVE:
  - LSM_BUSY = 1.
  - LSM_REG = index of the lowest set bit of the remaining list (combinational from the registered list).
  - LSM_END = 1 when exactly one bit remains.
  - LSM_STEP at an edge: clear the lowest set bit and increment LSM_INDEX.
  - If LSM_END was 1 on that step, go to IDLE. The list is now 0 and LSM_BUSY drops in the cycle after the last step.
  - LSM_STEP low: all outputs hold (memory stall). There is no timeout.
  - LSM_EN while ACTIVE is ignored; LSM_COUNT and the offsets stay stable for the whole sequence.
- EMPTY (empty register list):
  - One cycle with LSM_BUSY = 1, LSM_END = 1, LSM_REG = 0.
  - Always returns to IDLE on the next edge; LSM_STEP is not required.
  - The CU must not issue a memory cycle for this case.
- LSM_STEP in IDLE or EMPTY has no effect.
- LSM_STEP and LSM_EN in the same cycle: the state-specific rule applies (STEP in ACTIVE, EN in IDLE).
- Reset asserted mid-sequence aborts immediately, with no further LSM_END.
- Offsets, LSM_COUNT and LSM_INDEX keep their last values after return to IDLE until the next LSM_EN.
- The S bit (IR[22]), W bit (IR[21]) and L bit (IR[20]) are not interpreted here; the CU decodes them.

Test Plan:
- IR = 32'hE8BD000F (LDMIA sp!, {r0-r3}), LSM_EN pulse, then LSM_STEP every cycle:
  - LSM_DETECT = 1, COUNT = 4, START = 0, WB = 32'h10.
  - LSM_REG = 0, 1, 2, 3.
  - LSM_END high only while REG = 3.
  - BUSY low one cycle after the 4th step.
- IR = 32'hE92D4010 (STMDB sp!, {r4, lr}):
  - COUNT = 2, START = 32'hFFFFFFF8, WB = 32'hFFFFFFF8.
  - REG = 4 then 14; END with REG = 14.
- IR = 32'hE9900006 (LDMIB r0, {r1, r2}): START = 4, WB = 8.
- IR = 32'hE8100006 (LDMDA r0, {r1, r2}): START = 32'hFFFFFFFC, WB = 32'hFFFFFFF8.
- Stall case: hold LSM_STEP low for 5 cycles after the 1st step of {r0-r3}:
  - REG stays 1 and INDEX stays 1.
  - Resume: sequence completes normally.
- IR = 32'hE0800001 (ADD) with LSM_EN:
  - LSM_DETECT = 0, BUSY stays 0.
- IR = 32'hE8900000 (empty list):
  - One-cycle BUSY = END = 1, COUNT = 0, then IDLE.
- Assert RESET during the 2nd transfer of {r0-r3}:
  - All outputs go to 0 asynchronously.
  - A subsequent LSM_EN restarts from REG = 0.
